// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, fetch FSM states and
// the per-icode instruction-length table.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_OUT, S_WAIT_PC, S_HALTED} fetch_state_e;

    typedef struct packed {
        logic [3:0] len;
        logic       need_regids;
        logic       need_valc;
        logic       invalid;
    } ilen_t;

    function automatic ilen_t instr_info(input logic [3:0] icode);
        ilen_t r;
        r = '{len: 4'd1, need_regids: 1'b0, need_valc: 1'b0, invalid: 1'b0};
        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
                r.len = 4'd2; r.need_regids = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                r.len = 4'd10; r.need_regids = 1'b1; r.need_valc = 1'b1;
            end
            I_JXX, I_CALL: begin
                r.len = 4'd9; r.need_valc = 1'b1;
            end
            default: r.invalid = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational length/layout decode of an instruction's first byte.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       need_regids,
    output logic       need_valc,
    output logic       invalid
);
    ilen_t info;

    assign info        = instr_info(icode);
    assign len         = info.len;
    assign need_regids = info.need_regids;
    assign need_valc   = info.need_valc;
    assign invalid     = info.invalid;
endmodule

// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch: reads an instruction byte-serially from instruction
// memory, splits it into fields and hands it over on a valid/ready port.
module fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_new,
    input  logic        pc_load,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    output logic [2:0]  stat
);
    fetch_state_e state, state_nx;
    logic [3:0] byte_idx, len_q;
    logic       regs_q, valc_q;
    logic [3:0] dec_len;
    logic       dec_regids, dec_valc, dec_inv;
    logic       fetch_ack, last_byte, start_fetch;
    logic [2:0] vbyte;

    instr_len_decode u_len_dec (
        .icode      (imem_rdata[7:4]),
        .len        (dec_len),
        .need_regids(dec_regids),
        .need_valc  (dec_valc),
        .invalid    (dec_inv)
    );

    // Reset forces req low immediately; after release FETCH requests at once.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc + {60'b0, byte_idx};
    assign out_valid = (state == S_OUT);
    assign fetch_ack = imem_req && imem_ack;
    assign last_byte = (byte_idx == 4'd0) ? (dec_inv || dec_len == 4'd1)
                                          : (byte_idx == len_q - 4'd1);
    // Index into valC: skip byte 0 and, when present, the register byte.
    assign vbyte     = byte_idx[2:0] - (regs_q ? 3'd2 : 3'd1);
    assign start_fetch = (state == S_WAIT_PC && pc_load) ||
                         (state == S_OUT && out_ready && pc_load && stat == STAT_AOK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   if (fetch_ack && (imem_err || last_byte)) state_nx = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    if (stat != STAT_AOK) state_nx = S_HALTED;
                    else if (pc_load)     state_nx = S_FETCH;
                    else                  state_nx = S_WAIT_PC;
                end
            end
            S_WAIT_PC: if (pc_load) state_nx = S_FETCH;
            default:   state_nx = S_HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            byte_idx <= 4'd0;
            len_q    <= 4'd0;
            regs_q   <= 1'b0;
            valc_q   <= 1'b0;
            icode    <= 4'h0;
            ifun     <= 4'h0;
            rA       <= RNONE;
            rB       <= RNONE;
            valC     <= 64'h0;
            valP     <= 64'h0;
            stat     <= STAT_AOK;
        end else if (start_fetch) begin
            pc       <= pc_new;
            byte_idx <= 4'd0;
            icode    <= 4'h0;
            ifun     <= 4'h0;
            rA       <= RNONE;
            rB       <= RNONE;
            valC     <= 64'h0;
            valP     <= 64'h0;
            stat     <= STAT_AOK;
        end else if (fetch_ack) begin
            if (imem_err) begin
                stat <= STAT_ADR;
                valP <= pc + {60'b0, byte_idx};
                // A register byte that never arrived reads as zero, not RNONE.
                if (byte_idx == 4'd0 || (regs_q && byte_idx == 4'd1)) begin
                    rA <= 4'h0;
                    rB <= 4'h0;
                end
            end else if (byte_idx == 4'd0) begin
                icode    <= imem_rdata[7:4];
                ifun     <= imem_rdata[3:0];
                len_q    <= dec_len;
                regs_q   <= dec_regids;
                valc_q   <= dec_valc;
                byte_idx <= 4'd1;
                if (dec_inv) begin
                    stat <= STAT_INS;
                    valP <= pc + 64'd1;
                end else if (dec_len == 4'd1) begin
                    stat <= (imem_rdata[7:4] == I_HALT) ? STAT_HLT : STAT_AOK;
                    valP <= pc + 64'd1;
                end
            end else begin
                if (regs_q && byte_idx == 4'd1) begin
                    rA <= imem_rdata[7:4];
                    rB <= imem_rdata[3:0];
                end else if (valc_q) begin
                    valC[{vbyte, 3'b000} +: 8] <= imem_rdata;
                end
                byte_idx <= byte_idx + 4'd1;
                if (last_byte) valP <= pc + {60'b0, len_q};
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte memory model that supports
// configurable wait states and a single faulting address.
module tb_fetch_unit;
    logic        clk, rst;
    logic [63:0] pc_new;
    logic        pc_load;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        imem_err;
    logic        out_valid, out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic [2:0]  stat;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          delay = 0;
    bit          err_en = 0;
    logic [63:0] err_addr = 64'h0;
    logic [7:0]  mem [logic [63:0]];

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .pc_new(pc_new), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .pc(pc), .stat(stat)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bytes: byte 0 in the most significant used position
    task automatic load(input logic [63:0] base, input int n, input logic [79:0] bytes);
        for (int k = 0; k < n; k++) mem[base + 64'(k)] = bytes[8*(n-1-k) +: 8];
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory responder: decides ack on the falling edge for the next rising edge.
    initial begin
        int cnt;
        cnt = 0;
        imem_ack = 0; imem_rdata = 0; imem_err = 0;
        forever begin
            @(negedge clk);
            if (!imem_req) begin
                imem_ack = 0; imem_err = 0; cnt = 0;
            end else if (cnt >= delay) begin
                imem_ack   = 1;
                imem_rdata = rd(imem_addr);
                imem_err   = err_en && (imem_addr == err_addr);
                cnt = 0;
            end else begin
                imem_ack = 0; imem_err = 0; cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check(tag, out_valid, 1'b1);
    endtask

    task automatic handshake(input logic load_pc, input logic [63:0] npc);
        out_ready = 1; pc_load = load_pc; pc_new = npc;
        tick();
        out_ready = 0; pc_load = 0;
    endtask

    task automatic check_halted_quiet(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            pc_load = 1; pc_new = 64'h0;
            tick();
            pc_load = 0;
            if (imem_req || out_valid) bad++;
            tick();
            if (imem_req || out_valid) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        rst = 0; pc_new = 0; pc_load = 0; out_ready = 0;
        load(64'h0,  10, 80'h30F20A00000000000000);
        load(64'h20,  9, 80'h00_730001000000000000);
        load(64'h40,  4, 80'h000000000000_40120000);
        load(64'h80,  1, 80'hC0);
        load(64'h90,  1, 80'h00);
        load(64'hFFFF_FFFF_FFFF_FFFF, 1, 80'h60);
        #2 rst = 1;
        tick();

        // reset state
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_icode", icode, 4'h0);
        check("rst_rA", rA, 4'hF);
        check("rst_rB", rB, 4'hF);
        check("rst_valC", valC, 64'h0);
        check("rst_valP", valP, 64'h0);
        check("rst_stat", stat, 3'd1);
        check("rst_pc", pc, 64'h0);

        // irmovq from RESET_PC with zero-wait memory
        release_rst();
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 64'h0);
        repeat (9) @(posedge clk);
        #1;
        check("irmov_not_yet", out_valid, 1'b0);
        tick();
        check("irmov_valid", out_valid, 1'b1);
        check("irmov_req_low", imem_req, 1'b0);
        check("irmov_icode", icode, 4'h3);
        check("irmov_ifun", ifun, 4'h0);
        check("irmov_rA", rA, 4'hF);
        check("irmov_rB", rB, 4'h2);
        check("irmov_valC", valC, 64'd10);
        check("irmov_valP", valP, 64'd10);
        check("irmov_stat", stat, 3'd1);

        // handshake without pc_load parks in WAIT_PC
        handshake(1'b0, 64'h0);
        check("waitpc_valid", out_valid, 1'b0);
        check("waitpc_req", imem_req, 1'b0);
        tick();
        check("waitpc_idle", imem_req, 1'b0);
        pc_load = 1; pc_new = 64'h20;
        tick();
        pc_load = 0;
        check("jxx_addr0", imem_addr, 64'h20);

        // jXX with two wait states per byte and back-pressure
        delay = 2;
        wait_valid("jxx_valid_wait");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jxx_hold_valid", out_valid, 1'b1);
            check("jxx_hold_valC", valC, 64'h100);
        end
        check("jxx_icode", icode, 4'h7);
        check("jxx_ifun", ifun, 4'h3);
        check("jxx_rA", rA, 4'hF);
        check("jxx_rB", rB, 4'hF);
        check("jxx_valP", valP, 64'h29);
        check("jxx_pc", pc, 64'h20);

        // handshake with simultaneous pc_load goes straight to FETCH
        delay = 0;
        handshake(1'b1, 64'h40);
        check("direct_req", imem_req, 1'b1);
        check("direct_addr", imem_addr, 64'h40);
        check("one_handshake", out_valid, 1'b0);

        // rmmovq with a fault on byte 3
        err_en = 1; err_addr = 64'h43;
        wait_valid("adr_valid_wait");
        check("adr_stat", stat, 3'd3);
        check("adr_icode", icode, 4'h4);
        check("adr_rA", rA, 4'h1);
        check("adr_rB", rB, 4'h2);
        check("adr_valC", valC, 64'h0);
        err_en = 0;
        handshake(1'b1, 64'h60);
        check_halted_quiet("adr_halted");

        // reset mid-fetch
        rst = 1;
        release_rst();
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_icode", icode, 4'h0);
        check("midrst_rB", rB, 4'hF);
        check("midrst_valC", valC, 64'h0);
        check("midrst_pc", pc, 64'h0);
        release_rst();
        #1;
        check("midrst_restart_addr", imem_addr, 64'h0);
        wait_valid("midrst_valid_wait");
        check("midrst_re_valC", valC, 64'd10);
        check("midrst_re_pc", pc, 64'h0);

        // invalid icode C0
        handshake(1'b1, 64'h80);
        wait_valid("ins_valid_wait");
        check("ins_stat", stat, 3'd4);
        check("ins_icode", icode, 4'hC);
        check("ins_valP", valP, 64'h81);
        handshake(1'b1, 64'h0);
        check_halted_quiet("ins_halted");

        // PC wrap: 60 at FFFF..FF, 01 at 0
        rst = 1;
        release_rst();
        wait_valid("wrap_pre_valid");
        mem[64'h0] = 8'h01;
        handshake(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("wrap_addr1", imem_addr, 64'h0);
        tick();
        check("wrap_valid", out_valid, 1'b1);
        check("wrap_icode", icode, 4'h6);
        check("wrap_rA", rA, 4'h0);
        check("wrap_rB", rB, 4'h1);
        check("wrap_valP", valP, 64'h1);
        check("wrap_stat", stat, 3'd1);

        // halt
        handshake(1'b1, 64'h90);
        wait_valid("hlt_valid_wait");
        check("hlt_stat", stat, 3'd2);
        check("hlt_valP", valP, 64'h91);
        handshake(1'b1, 64'h0);
        check_halted_quiet("hlt_halted");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
